// File: rtl/data_bus_decoder.sv
// -----------------------------------------------------------------------------
// data_bus_decoder
//
// Address decoder and read-data mux between the CPU data master and the
// memory-mapped slaves (BIOS ROM, RAM, unmapped space). An access is captured
// in IDLE, and the decoded slave is held selected in WAIT until it acks. Unmapped
// accesses complete at once with 16'hFFFF. A mapped slave that stays silent for
// TIMEOUT cycles is force-completed with 16'hFFFF and a timeout_err pulse, so
// the master can never hang.
//
// Parameters
//   BIOS_BASE   first word address of the BIOS region (BIOS spans to 19'h7FFFF)
//   RAM_WORDS   RAM occupies word addresses 0 .. RAM_WORDS-1
//   TIMEOUT     WAIT cycles before a forced completion (>= 2)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   m_access/m_ack              master request (held) / one-cycle completion
//   m_addr, m_data_in           master word address, write data
//   m_wr_en, m_bytesel          master write strobe, byte lanes
//   m_data_out                  read data to master, 0 unless m_ack
//   s_access                    shared slave strobe, dropped in the ack cycle
//   s_addr, s_data_out          pass-through of m_addr, m_data_in
//   s_wr_en, s_bytesel          pass-through of m_wr_en, m_bytesel
//   bios_cs/bios_ack/bios_data  BIOS select, ack and read data
//   ram_cs/ram_ack/ram_data     RAM select, ack and read data
//   timeout_err                 one-cycle pulse on a forced completion
// -----------------------------------------------------------------------------
module data_bus_decoder #(
   parameter logic [18:0] BIOS_BASE = 19'h7E000,
   parameter logic [18:0] RAM_WORDS = 19'h50000,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic        clk,
   input  logic        reset,
   // master side
   input  logic        m_access,
   output logic        m_ack,
   input  logic [18:0] m_addr,
   input  logic [15:0] m_data_in,
   output logic [15:0] m_data_out,
   input  logic        m_wr_en,
   input  logic [1:0]  m_bytesel,
   // shared slave side
   output logic        s_access,
   output logic [18:0] s_addr,
   output logic [15:0] s_data_out,
   output logic        s_wr_en,
   output logic [1:0]  s_bytesel,
   // BIOS ROM
   output logic        bios_cs,
   input  logic        bios_ack,
   input  logic [15:0] bios_data,
   // RAM
   output logic        ram_cs,
   input  logic        ram_ack,
   input  logic [15:0] ram_data,
   // status
   output logic        timeout_err
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [15:0]      DATA_ERR = 16'hFFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_BIOS = 2'd1,
      SEL_RAM  = 2'd2
   } sel_e;

   state_e           state_q, state_d;
   sel_e             sel_q,   sel_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   sel_e             dec_sel;
   logic             sel_ack;
   logic [15:0]      sel_data;
   logic             cnt_last;

   // Write-side signals go straight through; only the selects are decoded.
   assign s_addr     = m_addr;
   assign s_data_out = m_data_in;
   assign s_wr_en    = m_wr_en;
   assign s_bytesel  = m_bytesel;

   // Address decode; BIOS takes priority so an overlapping RAM_WORDS cannot shadow it.
   always_comb begin : decode
      dec_sel = SEL_NONE;
      if (m_addr >= BIOS_BASE) begin
         dec_sel = SEL_BIOS;
      end else if (m_addr < RAM_WORDS) begin
         dec_sel = SEL_RAM;
      end
   end

   // Ack and data of the slave captured at the start of the access; others are ignored.
   always_comb begin : ack_mux
      sel_ack  = 1'b0;
      sel_data = '0;
      unique case (sel_q)
         SEL_BIOS: begin
            sel_ack  = bios_ack;
            sel_data = bios_data;
         end
         SEL_RAM: begin
            sel_ack  = ram_ack;
            sel_data = ram_data;
         end
         default: begin
            sel_ack  = 1'b0;
            sel_data = '0;
         end
      endcase
   end

   assign cnt_last = (cnt_q == CNT_LAST);

   // State, selection and wait counter registers.
   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: capture in IDLE, leave WAIT on ack, unmapped or timeout.
   always_comb begin : next_state
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (m_access) begin
               state_d = ST_WAIT;
               sel_d   = dec_sel;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sel_ack || (sel_q == SEL_NONE) || cnt_last) begin
               state_d = ST_IDLE;
               sel_d   = SEL_NONE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = SEL_NONE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs. Everything is quiet in IDLE and while reset is asserted, so a
   // reset that lands on an ack cycle still produces no completion.
   always_comb begin : out_logic
      m_ack       = 1'b0;
      m_data_out  = '0;
      timeout_err = 1'b0;
      s_access    = 1'b0;
      bios_cs     = 1'b0;
      ram_cs      = 1'b0;
      if ((state_q == ST_WAIT) && !reset) begin
         bios_cs  = (sel_q == SEL_BIOS);
         ram_cs   = (sel_q == SEL_RAM);
         // Dropping the strobe in the ack cycle keeps a registered-ack slave
         // from seeing the same request twice.
         s_access = ~sel_ack;
         if (sel_ack) begin
            m_ack      = 1'b1;
            m_data_out = sel_data;
         end else if (sel_q == SEL_NONE) begin
            m_ack      = 1'b1;
            m_data_out = DATA_ERR;
         end else if (cnt_last) begin
            m_ack       = 1'b1;
            m_data_out  = DATA_ERR;
            timeout_err = 1'b1;
         end
      end
   end

endmodule
